// File: rtl/i2c_slave_base.sv
// rtl/i2c_slave_base.sv - I2C slave front-end: bus sync, START/STOP, address match, byte shifter
module i2c_slave_base #(
  parameter logic [6:0] ADDRESS = 7'h0C
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       SCL,
  inout  wire        SDA,
  output logic       START,
  output logic       STOP,
  output logic       SEL,
  output logic       RD,
  input  logic       ACK,
  output logic       ACKO,
  input  logic [7:0] DI,
  output logic [7:0] DO
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_WR_BYTE,
    S_WR_ACK,
    S_RD_BYTE,
    S_RD_ACK,
    S_WAIT_STOP
  } state_t;

  logic [1:0] scl_sync_q;
  logic [1:0] sda_sync_q;
  logic       scl_prev_q;
  logic       sda_prev_q;

  state_t     state_q;
  logic [3:0] cnt_q;
  logic [7:0] shift_q;
  logic       slot_q;
  logic       ack_q;
  logic       sda_oe_q;
  logic       start_q;
  logic       stop_q;
  logic       sel_q;
  logic       rd_q;
  logic       acko_q;
  logic [7:0] do_q;

  logic scl_s;
  logic sda_s;
  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;

  // Open-drain: only ever pull low, otherwise float for the bus pull-up.
  assign SDA   = sda_oe_q ? 1'b0 : 1'bz;
  assign START = start_q;
  assign STOP  = stop_q;
  assign SEL   = sel_q;
  assign RD    = rd_q;
  assign ACKO  = acko_q;
  assign DO    = do_q;

  assign scl_s     = scl_sync_q[1];
  assign sda_s     = sda_sync_q[1];
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  // SDA edges only count as bus conditions when SCL was high on both samples.
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

  // Two-flop synchronizers plus one delayed copy for edge detection; idle bus reads high.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], SCL};
      sda_sync_q <= {sda_sync_q[0], SDA};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

  // Protocol FSM; SDA drive only changes on SCL falls, START/STOP, or reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      shift_q  <= 8'h00;
      slot_q   <= 1'b0;
      ack_q    <= 1'b0;
      sda_oe_q <= 1'b0;
      start_q  <= 1'b0;
      stop_q   <= 1'b0;
      sel_q    <= 1'b0;
      rd_q     <= 1'b0;
      acko_q   <= 1'b0;
      do_q     <= 8'h00;
    end else begin
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      if (start_det) begin
        start_q  <= 1'b1;
        sel_q    <= 1'b0;
        rd_q     <= 1'b0;
        cnt_q    <= 4'd0;
        slot_q   <= 1'b0;
        sda_oe_q <= 1'b0;
        state_q  <= S_ADDR;
      end else if (stop_det) begin
        stop_q   <= 1'b1;
        sel_q    <= 1'b0;
        rd_q     <= 1'b0;
        cnt_q    <= 4'd0;
        slot_q   <= 1'b0;
        sda_oe_q <= 1'b0;
        state_q  <= S_IDLE;
      end else begin
        case (state_q)
          S_ADDR: begin
            if (scl_rise) begin
              shift_q <= {shift_q[6:0], sda_s};
              if (cnt_q == 4'd7) begin
                cnt_q  <= 4'd0;
                slot_q <= 1'b0;
                // shift_q[6:0] holds the seven address bits; sda_s is R/W.
                if (shift_q[6:0] == ADDRESS) begin
                  sel_q   <= 1'b1;
                  rd_q    <= sda_s;
                  state_q <= S_ADDR_ACK;
                end else begin
                  state_q <= S_WAIT_STOP;
                end
              end else begin
                cnt_q <= cnt_q + 4'd1;
              end
            end
          end
          S_ADDR_ACK, S_WR_ACK: begin
            if (scl_fall) begin
              if (!slot_q) begin
                // Start of the ACK slot: latch the upper layer's decision.
                slot_q   <= 1'b1;
                ack_q    <= ACK;
                sda_oe_q <= ACK;
              end else begin
                slot_q <= 1'b0;
                cnt_q  <= 4'd0;
                if (!ack_q) begin
                  sda_oe_q <= 1'b0;
                  state_q  <= S_WAIT_STOP;
                end else if (state_q == S_ADDR_ACK && rd_q) begin
                  shift_q  <= DI;
                  sda_oe_q <= ~DI[7];
                  cnt_q    <= 4'd1;
                  state_q  <= S_RD_BYTE;
                end else begin
                  sda_oe_q <= 1'b0;
                  state_q  <= S_WR_BYTE;
                end
              end
            end
          end
          S_WR_BYTE: begin
            if (scl_rise) begin
              shift_q <= {shift_q[6:0], sda_s};
              if (cnt_q == 4'd7) begin
                do_q    <= {shift_q[6:0], sda_s};
                cnt_q   <= 4'd0;
                slot_q  <= 1'b0;
                state_q <= S_WR_ACK;
              end else begin
                cnt_q <= cnt_q + 4'd1;
              end
            end
          end
          S_RD_BYTE: begin
            // cnt_q counts bits already presented; bit7 went out on entry.
            if (scl_fall) begin
              if (cnt_q == 4'd8) begin
                sda_oe_q <= 1'b0;
                cnt_q    <= 4'd0;
                slot_q   <= 1'b0;
                state_q  <= S_RD_ACK;
              end else begin
                sda_oe_q <= ~shift_q[6];
                shift_q  <= {shift_q[6:0], 1'b0};
                cnt_q    <= cnt_q + 4'd1;
              end
            end
          end
          S_RD_ACK: begin
            if (scl_rise) begin
              acko_q <= ~sda_s;
              slot_q <= 1'b1;
            end else if (scl_fall && slot_q) begin
              slot_q <= 1'b0;
              if (acko_q) begin
                shift_q  <= DI;
                sda_oe_q <= ~DI[7];
                cnt_q    <= 4'd1;
                state_q  <= S_RD_BYTE;
              end else begin
                sda_oe_q <= 1'b0;
                state_q  <= S_WAIT_STOP;
              end
            end
          end
          default: begin
            sda_oe_q <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_base.sv
// tb/tb_i2c_slave_base.sv - randomized bit-banged I2C master with transaction-level model
module tb_i2c_slave_base;
  localparam logic [6:0] SLV = 7'h0C;
  localparam int Q = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       m_low = 1'b0;
  logic       ack_in = 1'b1;
  logic [7:0] di = 8'h00;
  wire        sda_bus;
  wire        start_o, stop_o, sel_o, rd_o, acko_o;
  wire  [7:0] do_o;

  int n_cmp = 0;
  int n_err = 0;
  int n_start = 0;
  int n_stop = 0;
  int n_drove = 0;

  logic [7:0] exp_do = 8'h00;
  logic [7:0] td[4];
  bit         ta[4];

  assign sda_bus = m_low ? 1'b0 : 1'bz;
  pullup (sda_bus);

  i2c_slave_base #(.ADDRESS(SLV)) dut (
    .clk_i(clk), .rst_i(rst), .SCL(scl), .SDA(sda_bus),
    .START(start_o), .STOP(stop_o), .SEL(sel_o), .RD(rd_o),
    .ACK(ack_in), .ACKO(acko_o), .DI(di), .DO(do_o)
  );

  always #5 clk = ~clk;

  // Bus monitor: count event pulses and any low level the master did not cause.
  always @(negedge clk) begin
    if (start_o) n_start++;
    if (stop_o) n_stop++;
    if (!m_low && sda_bus === 1'b0) n_drove++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    repeat (Q) @(negedge clk);
  endtask

  task automatic m_start();
    m_low = 1'b0; tick();
    scl = 1'b1;   tick();
    m_low = 1'b1; tick();
    scl = 1'b0;   tick();
  endtask

  task automatic m_stop();
    m_low = 1'b1; tick();
    scl = 1'b1;   tick();
    m_low = 1'b0; tick();
  endtask

  task automatic m_bit(input bit b, output bit s);
    m_low = ~b; tick();
    scl = 1'b1; tick();
    s = (sda_bus !== 1'b0);
    tick();
    scl = 1'b0; tick();
  endtask

  task automatic m_wbyte(input logic [7:0] b, output bit acked);
    bit s;
    for (int i = 7; i >= 0; i--) m_bit(b[i], s);
    m_bit(1'b1, s);
    acked = !s;
  endtask

  task automatic m_rbyte(output logic [7:0] d, input bit mack, input logic [7:0] next_di);
    bit s;
    for (int i = 7; i >= 0; i--) begin
      m_bit(1'b1, s);
      d[i] = s;
    end
    di = next_di;
    m_bit(!mack, s);
  endtask

  // One transaction: address byte ab, nb data bytes in td[], per-byte ACK (slave for
  // writes, master for reads) in ta[]; a_addr is the slave's decision on the address.
  task automatic run_txn(input string tag, input logic [7:0] ab, input bit a_addr, input int nb);
    bit         addressed, live, acked;
    logic [7:0] d, exp_d;
    int         s0, p0, dr0;
    addressed = (ab[7:1] == SLV);
    s0 = n_start; p0 = n_stop; dr0 = n_drove;
    m_start();
    ack_in = a_addr;
    di = td[0];
    m_wbyte(ab, acked);
    chk({tag, ":addr_ack"}, acked, addressed && a_addr);
    chk({tag, ":sel"}, sel_o, addressed);
    if (addressed) chk({tag, ":rd"}, rd_o, ab[0]);
    live = addressed && a_addr;
    for (int i = 0; i < nb; i++) begin
      if (!ab[0]) begin
        ack_in = ta[i];
        m_wbyte(td[i], acked);
        if (live) exp_do = td[i];
        chk({tag, ":wr_ack"}, acked, live && ta[i]);
        chk({tag, ":do"}, do_o, exp_do);
        live = live && ta[i];
      end else begin
        m_rbyte(d, ta[i], (i < 3) ? td[i+1] : 8'h00);
        exp_d = live ? td[i] : 8'hFF;
        chk({tag, ":rd_data"}, d, exp_d);
        if (live) chk({tag, ":acko"}, acko_o, ta[i]);
        live = live && ta[i];
      end
    end
    m_stop();
    tick();
    chk({tag, ":sel_after_stop"}, sel_o, 1'b0);
    chk({tag, ":start_cnt"}, n_start - s0, 1);
    chk({tag, ":stop_cnt"}, n_stop - p0, 1);
    chk({tag, ":do_final"}, do_o, exp_do);
    if (!addressed) chk({tag, ":never_driven"}, n_drove - dr0, 0);
  endtask

  initial begin
    bit         acked, s;
    logic [7:0] d, ab;
    logic [6:0] a7;
    int         s0, nb;

    repeat (4) @(negedge clk);
    chk("reset:start", start_o, 1'b0);
    chk("reset:stop", stop_o, 1'b0);
    chk("reset:sel", sel_o, 1'b0);
    chk("reset:rd", rd_o, 1'b0);
    chk("reset:acko", acko_o, 1'b0);
    chk("reset:do", do_o, 8'h00);
    chk("reset:sda", sda_bus, 1'b1);
    rst = 1'b0;
    tick();

    td[0] = 8'hA5; td[1] = 8'h3C; ta[0] = 1; ta[1] = 1;
    run_txn("write", 8'h18, 1'b1, 2);

    td[0] = 8'hFF; ta[0] = 1;
    run_txn("mismatch", 8'h1A, 1'b1, 1);

    td[0] = 8'h96; td[1] = 8'h5A; td[2] = 8'h00; ta[0] = 1; ta[1] = 0;
    run_txn("read", 8'h19, 1'b1, 2);

    td[0] = 8'h77; td[1] = 8'h11; td[2] = 8'h22; ta[0] = 0; ta[1] = 1; ta[2] = 1;
    run_txn("nack", 8'h18, 1'b1, 3);

    // Repeated START in the middle of a write data byte.
    s0 = n_start;
    m_start();
    ack_in = 1'b1;
    m_wbyte(8'h18, acked);
    chk("rstart:addr_ack", acked, 1'b1);
    for (int i = 0; i < 4; i++) m_bit(1'($urandom_range(0, 1)), s);
    di = 8'h3B;
    m_start();
    m_wbyte(8'h19, acked);
    chk("rstart:addr2_ack", acked, 1'b1);
    chk("rstart:rd", rd_o, 1'b1);
    chk("rstart:start_cnt", n_start - s0, 2);
    chk("rstart:do", do_o, exp_do);
    m_rbyte(d, 1'b0, 8'h00);
    chk("rstart:rd_data", d, 8'h3B);
    m_stop();
    tick();

    // Reset while the slave holds SDA low for a 0 read bit.
    m_start();
    di = 8'h12;
    ack_in = 1'b1;
    m_wbyte(8'h19, acked);
    chk("rst_mid:slave_drives", sda_bus, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid:sda", sda_bus, 1'b1);
    chk("rst_mid:sel", sel_o, 1'b0);
    chk("rst_mid:rd", rd_o, 1'b0);
    chk("rst_mid:acko", acko_o, 1'b0);
    chk("rst_mid:do", do_o, 8'h00);
    chk("rst_mid:start", start_o, 1'b0);
    rst = 1'b0;
    exp_do = 8'h00;
    tick();
    m_stop();
    tick();

    // Randomized transactions.
    for (int t = 0; t < 10; t++) begin
      if ($urandom_range(0, 2) != 0) begin
        a7 = SLV;
      end else begin
        a7 = 7'($urandom);
        if (a7 == SLV) a7 = a7 ^ 7'h01;
      end
      ab = {a7, 1'($urandom_range(0, 1))};
      nb = $urandom_range(1, 3);
      for (int i = 0; i < 4; i++) begin
        td[i] = 8'($urandom);
        ta[i] = ($urandom_range(0, 3) != 0);
      end
      if (ab[0]) ta[nb-1] = 1'b0;
      run_txn("rand", ab, ($urandom_range(0, 4) != 0), nb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
